// File: rtl/fir_input_sequencer.sv
// -----------------------------------------------------------------------------
// fir_input_sequencer
//   Front end of the FIR core. It synchronises the asynchronous pad strobe and
//   mode line, then edge-detects the strobe. Each strobe becomes one of two
//   things:
//     - a one-cycle sample handshake into the FIR delay line (sample mode), or
//     - one write into a shadow coefficient bank (coefficient mode).
//   A complete shadow bank is committed to coeffs_out in a single edge.
//
// Optional feature (macro FIR_SEQ_CHECKSUM_EN):
//   When defined, each load takes NUM_TAPS+1 strobes. The last byte is the XOR
//   of all coefficients, and the bank is committed only when it matches.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-high reset
//   data_in        raw sample/coefficient byte from the pads
//   valid_in       raw asynchronous strobe; a rising edge marks data_in valid
//   set_coeffs_in  raw asynchronous mode line (1 = coefficient load)
//   sample_data    sample presented to the FIR x_n input
//   sample_valid   one-cycle pulse qualifying sample_data
//   coeffs_out     committed coefficient bank, tap0 in the LSBs
//   coeffs_loaded  high while a successfully committed load is in DONE
//   coeff_index    bytes received in the current load sequence
//   load_error     sticky abort/checksum flag, cleared by the next commit
// -----------------------------------------------------------------------------
module fir_input_sequencer #(
  parameter int NUM_TAPS    = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int COEFF_RESET = 1,
`ifdef FIR_SEQ_CHECKSUM_EN
  localparam int LOAD_LEN   = NUM_TAPS + 1,
`else
  localparam int LOAD_LEN   = NUM_TAPS,
`endif
  localparam int IDX_W      = $clog2(LOAD_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       valid_in,
  input  logic                       set_coeffs_in,
  output logic [DATA_W-1:0]          sample_data,
  output logic                       sample_valid,
  output logic [NUM_TAPS*DATA_W-1:0] coeffs_out,
  output logic                       coeffs_loaded,
  output logic [IDX_W-1:0]           coeff_index,
  output logic                       load_error
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int                 BANK_W    = NUM_TAPS * DATA_W;
  localparam logic [DATA_W-1:0]  RST_BYTE  = DATA_W'(COEFF_RESET);
  localparam logic [BANK_W-1:0]  BANK_RST  = {NUM_TAPS{RST_BYTE}};
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(LOAD_LEN - 1);

  logic [SYNC_STAGES-1:0] valid_sync_q, valid_sync_d;
  logic [SYNC_STAGES-1:0] set_sync_q, set_sync_d;
  logic                   valid_hist_q, valid_hist_d;
  logic [1:0]             state_q, state_d;
  logic [BANK_W-1:0]      shadow_q, shadow_d;
  logic [BANK_W-1:0]      coeffs_q, coeffs_d;
  logic [DATA_W-1:0]      sample_data_q, sample_data_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   loaded_q, loaded_d;
  logic                   load_error_q, load_error_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic                   valid_s, set_s, strobe, accept;
  logic [BANK_W-1:0]      shadow_wr;
`ifdef FIR_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0]      checksum;
`endif

  // Synchroniser chains; the history flop makes a held-high strobe fire once.
  assign valid_sync_d = {valid_sync_q[SYNC_STAGES-2:0], valid_in};
  assign set_sync_d   = {set_sync_q[SYNC_STAGES-2:0], set_coeffs_in};
  assign valid_s      = valid_sync_q[SYNC_STAGES-1];
  assign set_s        = set_sync_q[SYNC_STAGES-1];
  assign valid_hist_d = valid_s;
  assign strobe       = valid_s & ~valid_hist_q;

  // A strobe is taken as a coefficient while set_s is high in IDLE or LOAD.
  // If set_s has already fallen in LOAD, the abort wins and the byte is dropped.
  assign accept = strobe & set_s & ((state_q == ST_IDLE) | (state_q == ST_LOAD));

  // Shadow bank with the incoming byte merged at coeff_index. The checksum slot
  // (index NUM_TAPS) matches no tap, so the bank passes through unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    shadow_wr = shadow_q;
    for (int t = 0; t < NUM_TAPS; t++) begin
      if (idx_q == IDX_W'(t)) shadow_wr[t*DATA_W +: DATA_W] = data_in;
    end
  end

`ifdef FIR_SEQ_CHECKSUM_EN
  always_comb begin
    checksum = '0;
    for (int t = 0; t < NUM_TAPS; t++) checksum ^= shadow_q[t*DATA_W +: DATA_W];
  end
`endif

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    coeffs_d       = coeffs_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = 1'b0;
    loaded_d       = loaded_q;
    load_error_d   = load_error_q;
    idx_d          = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (set_s) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end else if (strobe) begin
          sample_data_d  = data_in;
          sample_valid_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!set_s) begin
          // Mode dropped before the bank was complete: discard the shadow bank.
          state_d      = ST_IDLE;
          load_error_d = 1'b1;
          shadow_d     = BANK_RST;
          idx_d        = '0;
        end
      end
      ST_DONE: begin
        if (!set_s) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b0;
          idx_d    = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      shadow_d = shadow_wr;
      idx_d    = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
`ifdef FIR_SEQ_CHECKSUM_EN
        if (data_in == checksum) begin
          coeffs_d     = shadow_wr;
          loaded_d     = 1'b1;
          load_error_d = 1'b0;
        end else begin
          load_error_d = 1'b1;
        end
`else
        coeffs_d     = shadow_wr;
        loaded_d     = 1'b1;
        load_error_d = 1'b0;
`endif
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sync_q   <= '0;
      set_sync_q     <= '0;
      valid_hist_q   <= 1'b0;
      state_q        <= ST_IDLE;
      // NOTE: the coefficient banks are reset so no stale or partial load can leak out.
      shadow_q       <= BANK_RST;
      coeffs_q       <= BANK_RST;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      loaded_q       <= 1'b0;
      load_error_q   <= 1'b0;
      idx_q          <= '0;
    end else begin
      valid_sync_q   <= valid_sync_d;
      set_sync_q     <= set_sync_d;
      valid_hist_q   <= valid_hist_d;
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      coeffs_q       <= coeffs_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      loaded_q       <= loaded_d;
      load_error_q   <= load_error_d;
      idx_q          <= idx_d;
    end
  end

  assign sample_data   = sample_data_q;
  assign sample_valid  = sample_valid_q;
  assign coeffs_out    = coeffs_q;
  assign coeffs_loaded = loaded_q;
  assign coeff_index   = idx_q;
  assign load_error    = load_error_q;

endmodule
